jtag_trace_engine: RTL and testbench

//   Parametrised successor to the PC-poll trace controller. Accepts PC samples from the

---
 rtl/jtag_trace_engine.sv | 228 ++++++++++++++++++++++
 tb/tb_jtag_trace_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_trace_engine.sv
// PC-sample trace engine: optional table lookup (index out) or raw pass-through,
// consecutive-duplicate suppression, and a show-ahead FIFO drained over rts/cts.
`timescale 1ns/1ps
module jtag_trace_engine #(
  parameter int DATA_W      = 16,
  parameter int TABLE_DEPTH = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEDUP       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              rts,
  input  logic              cts,
  output logic              overflow,
  output logic              load_overflow,
  output logic [15:0]       miss_count
);

  localparam int ADDR_W = $clog2(TABLE_DEPTH);
  localparam int FPTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] TBL_FULL = (ADDR_W+1)'(TABLE_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [FPTR_W:0] PTR_ONE  = (FPTR_W+1)'(1);
  localparam logic [FPTR_W:0] PTR_MSB  = {1'b1, {FPTR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_EMIT   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          mode_q;
  logic [ADDR_W:0]     tbl_cnt_q;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   cand_q, cand_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   hist_q, hist_d;
  logic                hist_valid_q, hist_valid_d;
  logic [15:0]         miss_q, miss_d;
  logic                ovf_q, ovf_d;
  logic                lovf_q, lovf_d;
  logic [FPTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [FPTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic [DATA_W-1:0]   tbl_mem  [TABLE_DEPTH];
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic                tbl_full_s, tbl_we_s, sample_ready_s;
  logic                miss_inc_s, emit_s, dup_s, push_s, push_ok_s, pop_s;
  logic                full_s, empty_s;
  logic [FPTR_W:0]     count_s;
  logic [FPTR_W:0]     rd_next_s;

  assign tbl_full_s     = (tbl_cnt_q == TBL_FULL);
  assign tbl_we_s       = (mode_q == 2'd1) && load_valid && !tbl_full_s;
  assign sample_ready_s = (state_q == ST_IDLE) && mode_q[1];

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);
  assign count_s   = wr_ptr_q - rd_ptr_q;
  assign rd_next_s = rd_ptr_q + PTR_ONE;
  assign pop_s     = !empty_s && cts;

  // Sample FSM: accept, linear table search, then one emit cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cand_d     = cand_q;
    res_d      = res_q;
    miss_inc_s = 1'b0;
    emit_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_valid && sample_ready_s) begin
          cand_d = sample_data;
          if (mode_q == 2'd3) begin
            res_d   = sample_data;
            state_d = ST_EMIT;
          end else if (tbl_cnt_q == {(ADDR_W+1){1'b0}}) begin
            miss_inc_s = 1'b1;
          end else begin
            idx_d   = {ADDR_W{1'b0}};
            state_d = ST_SEARCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (tbl_mem[idx_q] == cand_q) begin
          res_d   = {{(DATA_W-ADDR_W){1'b0}}, idx_q};
          state_d = ST_EMIT;
        end else if ({1'b0, idx_q} == (tbl_cnt_q - CNT_ONE)) begin
          miss_inc_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      ST_EMIT: begin
        emit_s  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Dedup, FIFO pointer update, sticky flags and show-ahead head register.
  always_comb begin
    dup_s        = (DEDUP != 0) && hist_valid_q && (res_q == hist_q);
    push_s       = emit_s && !dup_s;
    push_ok_s    = push_s && (!full_s || pop_s);
    hist_d       = hist_q;
    hist_valid_d = hist_valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dout_d       = dout_q;
    ovf_d        = ovf_q | (push_s && full_s && !pop_s);
    lovf_d       = lovf_q | ((mode_q == 2'd1) && load_valid && tbl_full_s);
    if (push_s) begin
      hist_d       = res_q;
      hist_valid_d = 1'b1;
    end else begin
      hist_d = hist_q;
    end
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // The head register must track the entry that becomes the head on this edge.
    if (pop_s) begin
      rd_ptr_d = rd_next_s;
      if (count_s > PTR_ONE) begin
        dout_d = fifo_mem[rd_next_s[FPTR_W-1:0]];
      end else if (push_ok_s) begin
        dout_d = res_q;
      end else begin
        dout_d = dout_q;
      end
    end else if (empty_s && push_ok_s) begin
      dout_d = res_q;
    end else begin
      dout_d = dout_q;
    end
    if (miss_inc_s && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'd1;
    end else begin
      miss_d = miss_q;
    end
  end

  // Main state registers; reset discards any in-flight sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= mode;
      state_q      <= ST_IDLE;
      idx_q        <= {ADDR_W{1'b0}};
      cand_q       <= {DATA_W{1'b0}};
      res_q        <= {DATA_W{1'b0}};
      hist_q       <= {DATA_W{1'b0}};
      hist_valid_q <= 1'b0;
      miss_q       <= 16'd0;
      ovf_q        <= 1'b0;
      lovf_q       <= 1'b0;
      wr_ptr_q     <= {(FPTR_W+1){1'b0}};
      rd_ptr_q     <= {(FPTR_W+1){1'b0}};
      dout_q       <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cand_q       <= cand_d;
      res_q        <= res_d;
      hist_q       <= hist_d;
      hist_valid_q <= hist_valid_d;
      miss_q       <= miss_d;
      ovf_q        <= ovf_d;
      lovf_q       <= lovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
    end
  end

  // Table fill pointer survives resets unless reset is taken in program mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (mode == 2'd1) begin
        tbl_cnt_q <= {(ADDR_W+1){1'b0}};
      end else begin
        tbl_cnt_q <= tbl_cnt_q;
      end
    end else if (tbl_we_s) begin
      tbl_cnt_q <= tbl_cnt_q + CNT_ONE;
    end else begin
      tbl_cnt_q <= tbl_cnt_q;
    end
  end

  // Storage arrays (no reset on contents).
  always_ff @(posedge clk) begin
    if (!reset && tbl_we_s) begin
      tbl_mem[tbl_cnt_q[ADDR_W-1:0]] <= load_data;
    end
    if (!reset && push_ok_s) begin
      fifo_mem[wr_ptr_q[FPTR_W-1:0]] <= res_q;
    end
  end

  assign sample_ready  = sample_ready_s;
  assign data_out      = dout_q;
  assign rts           = !empty_s;
  assign overflow      = ovf_q;
  assign load_overflow = lovf_q;
  assign miss_count    = miss_q;

endmodule

// File: tb/tb_jtag_trace_engine.sv
// Scoreboard bench for jtag_trace_engine: directed stimulus pushes expected FIFO
// output; a forked monitor pops and compares on every rts&&cts transfer.
`timescale 1ns/1ps
module tb_jtag_trace_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        load_valid;
  logic [15:0] load_data;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic [15:0] data_out;
  logic        rts;
  logic        cts;
  logic        overflow;
  logic        load_overflow;
  logic [15:0] miss_count;

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  jtag_trace_engine #(
    .DATA_W(16), .TABLE_DEPTH(64), .FIFO_DEPTH(16), .DEDUP(1)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .load_valid(load_valid), .load_data(load_data),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .data_out(data_out), .rts(rts), .cts(cts),
    .overflow(overflow), .load_overflow(load_overflow), .miss_count(miss_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens on the edge following a negedge that sees rts&&cts.
  task automatic monitor_loop();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rts === 1'b1 && cts === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual=%0h required=none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {16'd0, data_out}, {16'd0, e});
        end
      end
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset = 1'b1; mode = m; load_valid = 1'b0; sample_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [15:0] d);
    load_valid = 1'b1; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    sample_valid = 1'b1; sample_data = d;
    for (int k = 0; k < 300; k++) begin
      if (sample_ready) begin
        tick();
        sample_valid = 1'b0;
        return;
      end
      tick();
    end
    sample_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_timeout actual=no_accept required=accept data=%0h", d);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !rts) break;
      tick();
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic wait_rts(input int limit, output int n);
    n = 999;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (rts) begin n = k; break; end
    end
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 999;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (sample_ready) begin n = k; break; end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 2'd0; load_valid = 1'b0; load_data = 16'd0;
    sample_valid = 1'b0; sample_data = 16'd0; cts = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset state
    do_reset(2'd0);
    chk("rst_ready_m0", sample_ready, 32'd0);
    chk("rst_rts", rts, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_overflow", overflow, 32'd0);
    chk("rst_load_ovf", load_overflow, 32'd0);
    chk("rst_miss", miss_count, 32'd0);

    // Test 1: lookup hit at index 2, pushed 4 edges after accept
    do_reset(2'd1);
    load(16'h1000); load(16'h1004); load(16'h1008);
    do_reset(2'd2);
    chk("rst_ready_m2", sample_ready, 32'd1);
    cts = 1'b1;
    exp_q.push_back(16'h0002);
    send(16'h1008);
    wait_rts(20, lat);
    chk("lookup_latency", lat, 32'd4);
    wait_drain();
    chk("t1_miss", miss_count, 32'd0);

    // Test 2: miss with 3 entries, then empty-table miss
    send(16'h2000);
    wait_ready(20, lat);
    chk("miss_ready_latency", lat, 32'd3);
    chk("t2_miss", miss_count, 32'd1);
    chk("t2_rts", rts, 32'd0);
    do_reset(2'd1);
    do_reset(2'd2);
    send(16'h1000);
    chk("empty_tbl_ready", sample_ready, 32'd1);
    chk("empty_tbl_miss", miss_count, 32'd1);
    tick(); tick();
    chk("empty_tbl_rts", rts, 32'd0);

    // Test 3: raw mode dedup
    do_reset(2'd3);
    cts = 1'b1;
    exp_q.push_back(16'h000A); exp_q.push_back(16'h000B); exp_q.push_back(16'h000A);
    send(16'h000A); send(16'h000A); send(16'h000B); send(16'h000A);
    tick(); tick();
    wait_drain();

    // Test 4: fill FIFO, overflow on 17th, then drain in order
    do_reset(2'd3);
    cts = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(16'h0100 + 16'(i));
      send(16'h0100 + 16'(i));
    end
    tick(); tick();
    chk("t4_overflow", overflow, 32'd1);
    chk("t4_rts_full", rts, 32'd1);
    chk("t4_head", data_out, 32'h0100);
    cts = 1'b1;
    wait_drain();
    chk("t4_rts_after", rts, 32'd0);
    chk("t4_hold_last", data_out, 32'h010F);

    // Test 5: 64 loads fill table, 65th flags load_overflow; last entry lookup
    do_reset(2'd1);
    for (int i = 0; i < 64; i++) load(16'h5000 + 16'(i));
    chk("t5_lovf_at_full", load_overflow, 32'd0);
    load(16'h5040);
    chk("t5_lovf", load_overflow, 32'd1);
    do_reset(2'd2);
    chk("t5_lovf_cleared", load_overflow, 32'd0);
    exp_q.push_back(16'h003F);
    send(16'h503F);
    wait_rts(100, lat);
    chk("t5_idx63_latency", lat, 32'd65);
    wait_drain();
    send(16'h5040);
    wait_ready(100, lat);
    chk("t5_full_miss_latency", lat, 32'd64);
    chk("t5_miss", miss_count, 32'd1);

    // Test 6: reset during SEARCH discards the sample; table survives mode-2 reset
    do_reset(2'd2);
    send(16'h5028);
    for (int i = 0; i < 10; i++) tick();
    do_reset(2'd2);
    chk("t6_rts", rts, 32'd0);
    chk("t6_miss", miss_count, 32'd0);
    chk("t6_ready", sample_ready, 32'd1);
    for (int i = 0; i < 50; i++) tick();
    chk("t6_no_push", rts, 32'd0);
    exp_q.push_back(16'h0005);
    send(16'h5005);
    wait_rts(20, lat);
    chk("t6_table_intact", lat, 32'd7);
    wait_drain();
    chk("t6_miss_after", miss_count, 32'd0);

    tick(); tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
